// File: rtl/bitmod_pkg.sv
// Shared types for the bit-serial weight path:
// decode modes, per-mode decode-cycle counts and scheduler states.
package bitmod_pkg;

    typedef enum logic [1:0] {
        MODE_INT8 = 2'd0,
        MODE_INT6 = 2'd1,
        MODE_FP4  = 2'd2,
        MODE_ILL  = 2'd3
    } mode_e;

    localparam logic [2:0] DEC_CYC_INT8 = 3'd4;
    localparam logic [2:0] DEC_CYC_INT6 = 3'd4;
    localparam logic [2:0] DEC_CYC_FP4  = 3'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_RUN,
        S_DONE
    } state_e;

endpackage

// File: rtl/dec_cyc_lut.sv
// Number of decoder digit cycles for a given weight mode.
module dec_cyc_lut
    import bitmod_pkg::*;
(
    input  mode_e      mode,
    output logic [2:0] n
);

    always_comb begin
        n = DEC_CYC_INT8;
        unique case (1'b1)
            (mode == MODE_INT6): n = DEC_CYC_INT6;
            (mode == MODE_FP4):  n = DEC_CYC_FP4;
            default:             n = DEC_CYC_INT8;
        endcase
    end

endmodule

// File: rtl/bitserial_sched.sv
// Tile command sequencer: fetches packed weights from SRAM and
// issues them back-to-back to the bit-serial decoder.
module bitserial_sched
    import bitmod_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_mode,
    input  logic [ADDR_W-1:0] cmd_base,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              hold,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [7:0]        mem_rd_data,
    output logic              dec_go,
    output logic [1:0]        dec_mode,
    output logic [7:0]        dec_data,
    output logic              dec_active,
    output logic              dec_last,
    output logic              busy,
    output logic              done,
    output logic              err
);

    state_e            state, nxt;
    mode_e             mode_q;
    logic [ADDR_W-1:0] base_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  idx;
    logic [2:0]        run_cnt;
    logic [2:0]        n_cyc;
    logic              err_q;
    logic              accept;
    logic              legal;
    logic              remain;
    logic              last_dig;

    dec_cyc_lut u_lut (
        .mode (mode_q),
        .n    (n_cyc)
    );

    assign legal    = (cmd_mode != 2'd3);
    assign accept   = (state == S_IDLE) && cmd_valid;
    assign remain   = (idx != len_q);
    assign last_dig = (run_cnt == n_cyc - 3'd1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            mode_q  <= MODE_INT8;
            base_q  <= '0;
            len_q   <= '0;
            idx     <= '0;
            run_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            state <= nxt;
            err_q <= accept && !legal;
            if (accept && legal) begin
                mode_q <= mode_e'(cmd_mode);
                base_q <= cmd_base;
                len_q  <= cmd_len;
                idx    <= '0;
            end
            if (state == S_ISSUE) begin
                idx     <= idx + 1'b1;
                run_cnt <= '0;
            end else if (state == S_RUN) begin
                run_cnt <= run_cnt + 3'd1;
            end
        end
    end

    // A weight's final digit doubles as the fetch slot for the next one.
    always_comb begin
        nxt        = state;
        cmd_ready  = 1'b0;
        mem_rd_en  = 1'b0;
        dec_go     = 1'b0;
        dec_active = 1'b0;
        dec_last   = 1'b0;
        done       = 1'b0;
        unique case (state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid && legal)
                    nxt = (cmd_len == '0) ? S_DONE : S_FETCH;
            end
            S_FETCH: begin
                if (!hold) begin
                    mem_rd_en = 1'b1;
                    nxt       = S_ISSUE;
                end
            end
            S_ISSUE: begin
                dec_go = 1'b1;
                nxt    = S_RUN;
            end
            S_RUN: begin
                dec_active = 1'b1;
                if (last_dig) begin
                    dec_last = 1'b1;
                    if (!remain) begin
                        nxt = S_DONE;
                    end else if (hold) begin
                        nxt = S_FETCH;
                    end else begin
                        mem_rd_en = 1'b1;
                        nxt       = S_ISSUE;
                    end
                end
            end
            S_DONE: begin
                done = 1'b1;
                nxt  = S_IDLE;
            end
            default: nxt = S_IDLE;
        endcase
    end

    assign mem_rd_addr = mem_rd_en ? base_q + ADDR_W'(idx) : '0;
    assign dec_data    = dec_go ? mem_rd_data : 8'h00;
    assign dec_mode    = mode_q;
    assign busy        = (state != S_IDLE);
    assign err         = err_q;

endmodule

// File: tb/tb_bitserial_sched.sv
// Scoreboard bench for bitserial_sched: stimulus queues timed events,
// a negedge monitor pops and compares whenever the DUT emits one.
module tb_bitserial_sched;

    typedef struct {
        int         cyc;
        logic [9:0] val;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_mode = 2'd0;
    logic [7:0] cmd_base = 8'h00;
    logic [7:0] cmd_len = 8'h00;
    logic       hold = 1'b0;
    logic       mem_rd_en;
    logic [7:0] mem_rd_addr;
    logic [7:0] mem_rd_data = 8'h00;
    logic       dec_go;
    logic [1:0] dec_mode;
    logic [7:0] dec_data;
    logic       dec_active;
    logic       dec_last;
    logic       busy;
    logic       done;
    logic       err;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int act_cnt = 0;

    ev_t rd_q[$];
    ev_t go_q[$];
    ev_t last_q[$];
    ev_t done_q[$];
    ev_t err_q[$];

    bitserial_sched #(.ADDR_W(8), .LEN_W(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_mode    (cmd_mode),
        .cmd_base    (cmd_base),
        .cmd_len     (cmd_len),
        .hold        (hold),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data),
        .dec_go      (dec_go),
        .dec_mode    (dec_mode),
        .dec_data    (dec_data),
        .dec_active  (dec_active),
        .dec_last    (dec_last),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] memv(input logic [7:0] a);
        return a * 8'd3 + 8'd1;
    endfunction

    always @(posedge clk)
        if (mem_rd_en) mem_rd_data <= memv(mem_rd_addr);

    task automatic cmp_ev(input string nm, input ev_t e,
                          input logic [9:0] act);
        checks++;
        if (e.cyc != cyc || e.val !== act) begin
            failures++;
            $display("FAIL %s: got cyc=%0d val=%h, want cyc=%0d val=%h",
                     nm, cyc, act, e.cyc, e.val);
        end
    endtask

    task automatic unexp(input string nm, input logic [9:0] act);
        checks++;
        failures++;
        $display("FAIL %s: unexpected event cyc=%0d val=%h, want none",
                 nm, cyc, act);
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (dec_active) act_cnt++;
            if (mem_rd_en) begin
                if (rd_q.size() == 0) unexp("rd", {2'b00, mem_rd_addr});
                else cmp_ev("rd", rd_q.pop_front(), {2'b00, mem_rd_addr});
            end
            if (dec_go) begin
                if (go_q.size() == 0) unexp("go", {dec_mode, dec_data});
                else cmp_ev("go", go_q.pop_front(), {dec_mode, dec_data});
            end
            if (dec_last) begin
                if (last_q.size() == 0) unexp("last", {9'd0, dec_active});
                else cmp_ev("last", last_q.pop_front(), {9'd0, dec_active});
            end
            if (done) begin
                if (done_q.size() == 0) unexp("done", {9'd0, busy});
                else cmp_ev("done", done_q.pop_front(), {9'd0, busy});
            end
            if (err) begin
                if (err_q.size() == 0) unexp("err", {9'd0, cmd_ready});
                else cmp_ev("err", err_q.pop_front(), {9'd0, cmd_ready});
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    task automatic chk_rst(input string nm);
        logic [27:0] o;
        o = {mem_rd_en, mem_rd_addr, dec_go, dec_mode, dec_data,
             dec_active, dec_last, busy, done, err, 1'b0};
        chk({nm, "_outs"}, int'(o), 0);
        chk({nm, "_ready"}, int'(cmd_ready), 1);
    endtask

    task automatic issue(input logic [1:0] m, input logic [7:0] b,
                         input logic [7:0] l, output int t);
        @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_mode  = m;
        cmd_base  = b;
        cmd_len   = l;
        t         = cyc;
    endtask

    task automatic push_int8_len2(input int t, input logic [7:0] b);
        logic [7:0] b1;
        b1 = b + 8'd1;
        rd_q.push_back('{t + 1, {2'b00, b}});
        rd_q.push_back('{t + 6, {2'b00, b1}});
        go_q.push_back('{t + 2, {2'd0, memv(b)}});
        go_q.push_back('{t + 7, {2'd0, memv(b1)}});
        last_q.push_back('{t + 6, 10'd1});
        last_q.push_back('{t + 11, 10'd1});
        done_q.push_back('{t + 12, 10'd1});
    endtask

    initial begin
        int t;
        int a0;

        #2;
        chk_rst("reset_async");
        step(2);
        chk_rst("reset_held");
        reset = 1'b0;
        step(2);
        chk("idle_ready", int'(cmd_ready), 1);

        // int8, base 0x10, len 2
        issue(2'd0, 8'h10, 8'd2, t);
        a0 = act_cnt;
        push_int8_len2(t, 8'h10);
        step(1);
        cmd_valid = 1'b0;
        chk("int8_ready_busy", int'(cmd_ready), 0);
        chk("int8_busy", int'(busy), 1);
        step(14);
        chk("int8_active", act_cnt - a0, 8);

        // fp4, len 1, cmd_valid left high while busy
        issue(2'd2, 8'h40, 8'd1, t);
        a0 = act_cnt;
        rd_q.push_back('{t + 1, 10'h040});
        go_q.push_back('{t + 2, {2'd2, memv(8'h40)}});
        last_q.push_back('{t + 5, 10'd1});
        done_q.push_back('{t + 6, 10'd1});
        step(3);
        cmd_valid = 1'b0;
        step(6);
        chk("fp4_active", act_cnt - a0, 3);

        // int6, len 3, hold across first weight boundary
        issue(2'd1, 8'h20, 8'd3, t);
        a0 = act_cnt;
        rd_q.push_back('{t + 1, 10'h020});
        rd_q.push_back('{t + 10, 10'h021});
        rd_q.push_back('{t + 15, 10'h022});
        go_q.push_back('{t + 2, {2'd1, memv(8'h20)}});
        go_q.push_back('{t + 11, {2'd1, memv(8'h21)}});
        go_q.push_back('{t + 16, {2'd1, memv(8'h22)}});
        last_q.push_back('{t + 6, 10'd1});
        last_q.push_back('{t + 15, 10'd1});
        last_q.push_back('{t + 20, 10'd1});
        done_q.push_back('{t + 21, 10'd1});
        step(1);
        cmd_valid = 1'b0;
        step(4);
        hold = 1'b1;
        step(5);
        hold = 1'b0;
        step(14);
        chk("int6_active", act_cnt - a0, 12);

        // len 0
        issue(2'd0, 8'h30, 8'd0, t);
        done_q.push_back('{t + 1, 10'd1});
        step(1);
        cmd_valid = 1'b0;
        step(3);

        // illegal mode
        issue(2'd3, 8'h30, 8'd2, t);
        err_q.push_back('{t + 1, 10'd1});
        step(1);
        cmd_valid = 1'b0;
        chk("ill_ready", int'(cmd_ready), 1);
        chk("ill_busy", int'(busy), 0);
        step(4);

        // address wrap
        issue(2'd0, 8'hFF, 8'd2, t);
        push_int8_len2(t, 8'hFF);
        step(1);
        cmd_valid = 1'b0;
        step(14);

        // reset during RUN of weight 2
        issue(2'd0, 8'h10, 8'd2, t);
        rd_q.push_back('{t + 1, 10'h010});
        rd_q.push_back('{t + 6, 10'h011});
        go_q.push_back('{t + 2, {2'd0, memv(8'h10)}});
        go_q.push_back('{t + 7, {2'd0, memv(8'h11)}});
        last_q.push_back('{t + 6, 10'd1});
        step(1);
        cmd_valid = 1'b0;
        step(8);
        chk("pre_rst_active", int'(dec_active), 1);
        #2;
        reset = 1'b1;
        #1;
        chk_rst("mid_reset");
        step(2);
        reset = 1'b0;
        step(2);

        // fresh command after abort
        issue(2'd0, 8'h10, 8'd2, t);
        a0 = act_cnt;
        push_int8_len2(t, 8'h10);
        step(1);
        cmd_valid = 1'b0;
        step(14);
        chk("rerun_active", act_cnt - a0, 8);

        chk("rd_left", rd_q.size(), 0);
        chk("go_left", go_q.size(), 0);
        chk("last_left", last_q.size(), 0);
        chk("done_left", done_q.size(), 0);
        chk("err_left", err_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bitserial_sched.md
# bitserial_sched

Command-driven sequencer for the bit-serial weight decoder in a PE. It accepts a tile command (mode, base address, weight count), fetches packed weight bytes from the local weight SRAM, and issues them one at a time to the decoder. Each go is timed so the decoder is idle exactly when it arrives. It drives per-digit framing to the accumulator and reports completion, keeping the decoder back-to-back busy unless the downstream requests a hold.

## Interface
- ADDR_W, 8, weight SRAM address width
- LEN_W, 8, weight-count width
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  scheduler can accept a command (high only in IDLE)
- cmd_mode  in  2  0 int8, 1 int6, 2 fp4, 3 illegal
- cmd_base  in  ADDR_W  first weight address
- cmd_len  in  LEN_W  number of weights (0 legal)
- hold  in  1  downstream backpressure, sampled only at weight boundaries
- mem_rd_en  out  1  SRAM read strobe; data valid the next cycle
- mem_rd_addr  out  ADDR_W  read address
- mem_rd_data  in  8  read data
- dec_go  out  1  one-cycle start pulse to decoder
- dec_mode  out  2  mode to decoder, stable for the whole command
- dec_data  out  8  weight byte; equals mem_rd_data while dec_go is high, otherwise 0
- dec_active  out  1  decoder is emitting a valid digit this cycle
- dec_last  out  1  final digit of the current weight
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse, command finished
- err  out  1  one-cycle pulse, illegal mode rejected

## Operation
- States: IDLE, FETCH, ISSUE, RUN, DONE.
- Decode-cycle count N per mode: int8 4, int6 4, fp4 3. Decoder issue period is N+1.
- **IDLE:** on cmd_valid, latch mode/base/len.
  - mode 3 -> err pulse next cycle, stay IDLE.
  - len 0 -> DONE.
  - else -> FETCH.
- **FETCH:** if hold, wait. Else assert mem_rd_en with addr = base+idx -> ISSUE.
- **ISSUE:** dec_go=1, dec_data=mem_rd_data, then idx++, run_cnt=0 -> RUN.
- **RUN:** dec_active=1, run_cnt++. dec_last=1 when run_cnt==N-1. On that cycle:
  - weights remain and !hold -> mem_rd_en for next address, then ISSUE (prefetch, no bubble).
  - weights remain and hold -> FETCH.
  - none remain -> DONE.
- **DONE:** done=1 -> IDLE.
- Address increments mod 2^ADDR_W; wrap is legal.
- hold is ignored within a weight; the decoder cannot stall mid-weight.

## Timing
- Reset values: all outputs 0 except cmd_ready=1. State IDLE, counters 0.
- Command accepted at cycle T -> FETCH T+1 -> dec_go T+2 -> RUN T+3..T+2+N.
- Back-to-back weights: dec_go spacing exactly N+1 cycles.
- done arrives one cycle after the last dec_last.
- Reset mid-command aborts immediately, with no done. The decoder shares reset, so both return to idle together.
- cmd_valid during busy is ignored (cmd_ready=0).

## Structure
- Shared package `bitmod_pkg`:
  - mode enum (MODE_INT8/INT6/FP4)
  - decode-cycle constants DEC_CYC_INT8=4, DEC_CYC_INT6=4, DEC_CYC_FP4=3
  - scheduler state enum
- Sub-module `dec_cyc_lut`: mode -> N (combinational).
- Counters and FSM live in the top module.

## Test plan
- int8, base 0x10, len 2, hold=0, accept at T:
  - rd_addr 0x10 at T+1, 0x11 at T+6
  - dec_go at T+2 and T+7
  - dec_last at T+6 and T+11
  - done at T+12
- fp4, len 1: dec_go at T+2; dec_active T+3..T+5; dec_last at T+5; done at T+6.
- int6, len 3, hold high across the first boundary for 3 cycles: FETCH waits 3 cycles, then dec_go spacing returns to 5. dec_active is never high while hold stalls.
- len 0: no mem_rd_en, no dec_go; done at T+1. mode 3: err at T+1, no done, cmd_ready stays 1.
- base 0xFF, len 2: read addresses 0xFF then 0x00.
- reset asserted during RUN of weight 2: all outputs go to their reset values asynchronously. No done. A fresh command afterwards behaves identically to the first scenario.
